regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file with write-through bypass and a per-register pending scoreboard. It is the next-generation architectural register file of the pipelined core. Two write ports serve the ALU writeback and the memory/load return, and a reserve port marks registers whose load is in flight so decode can stall on load-use hazards. Reads are combinational; writes and scoreboard updates are registered.

## Interface
- DATA_W, 24, register width
- NREGS, 16, register count (power of two, ≥4)
- ADDR_W, $clog2(NREGS), address width
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, if 1 register 0 reads 0 and ignores writes/reserves

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous reset, active-low
- rd_addr  in  NRD×ADDR_W  read addresses
- rd_data  out  NRD×DATA_W  read data
- rd_pending  out  NRD  addressed register has a load outstanding
- wa_en / wa_addr / wa_data  in  1 / ADDR_W / DATA_W  ALU write port
- wb_en / wb_addr / wb_data  in  1 / ADDR_W / DATA_W  load-return write port
- rsv_en / rsv_addr  in  1 / ADDR_W  mark register pending
- flush  in  1  clear all pending bits
- pending_cnt  out  ADDR_W+1  number of pending registers

## Operation
- Reset (rst_n low, async): registers load INIT table from package (r0=0x000000, r1=0x001000, r2=0x01CAC5, r3=0x03FFFF, r4=0x03858C, r5=0x03EFFF, rest 0; entries beyond table = 0); all pending bits 0; pending_cnt=0.
- Read, per port, priority: ZERO_REG && addr==0 → 0; wa_en && wa_addr==addr → wa_data; wb_en && wb_addr==addr → wb_data; else stored value.
- Write: at posedge, wa then wb committed; same address both enabled → wa_data stored (port A wins). Writes to r0 dropped when ZERO_REG=1.
- Scoreboard, per register, next-state priority: flush → 0; rsv_en && rsv_addr==i → 1; wb_en && wb_addr==i → 0; wa_en && wa_addr==i → 0; else hold.
- rd_pending = pending[addr] AND NOT (same-cycle wa/wb write to addr); 0 for r0 when ZERO_REG=1.
- Reserve to r0 with ZERO_REG=1 ignored. Reserve on already-pending register: stays 1, no error.
- pending_cnt = population count of pending bits, registered (updated with the bits).

## Timing
- Read latency 0 (combinational from rd_addr and write ports).
- Write visible on rd_data same cycle via bypass, from storage from next cycle.
- Reserve: rd_pending rises the cycle after rsv_en.
- Clear: rd_pending drops in the write cycle (bypass), bit cleared at that edge.
- flush takes effect at next edge; overrides same-cycle rsv_en.
- rst_n assertion mid-operation: immediate, no clock needed; deassertion synchronous use only, no pending writes survive.

## Structure
- Package regfile_pkg: default DATA_W/NREGS, INIT_VALUES array constant, reg_addr_t/reg_data_t typedefs.
- Sub-module regfile_scoreboard: pending bits, flush/reserve/clear priority, popcount → pending_cnt, plus rd_pending masking inputs. Storage and bypass mux stay in regfile_mp.

## Test plan
- Reset then read r1..r5 and r9 → 0x001000, 0x01CAC5, 0x03FFFF, 0x03858C, 0x03EFFF, 0; pending_cnt=0.
- wa_en write r7=0x123456 while rd_addr[0]=7 → rd_data[0]=0x123456 same cycle and following cycles; write r0=0xFFFFFF → r0 reads 0.
- wa and wb both to r3 (0x000AAA, 0x000BBB) → bypass and stored value 0x000AAA.
- rsv r4 → next cycle rd_pending=1, pending_cnt=1; wb write r4=0x000055 → rd_pending 0 that cycle, pending_cnt=0 next.
- rsv r2, r6, r8 over 3 cycles → pending_cnt=3; flush with rsv_en r9 same cycle → all 0, pending_cnt=0.
- Async reset mid-sequence with r4 pending, no clock edge → r4 back to 0x03858C, rd_pending=0 immediately.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults, reset image and typedefs for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int NREGS_DEF  = 16;
    localparam int ADDR_W_DEF = $clog2(NREGS_DEF);
    localparam int INIT_LEN   = 6;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

    localparam logic [23:0] INIT_VALUES [INIT_LEN] = '{
        24'h000000, 24'h001000, 24'h01CAC5,
        24'h03FFFF, 24'h03858C, 24'h03EFFF
    };

    // Registers past the end of the table come out of reset as zero.
    function automatic logic [23:0] init_value(input int idx);
        logic [23:0] v;
        v = '0;
        for (int k = 0; k < INIT_LEN; k++) begin
            if (k == idx) v = INIT_VALUES[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register load-pending bits with flush/reserve/clear priority and a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0]             rd_pending,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            pending_cnt
);

    logic [NREGS-1:0] pend_q, pend_d;
    logic [ADDR_W:0]  cnt_q, cnt_d;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    always_comb begin
        pend_d = pend_q;
        cnt_d  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (flush)
                pend_d[i] = 1'b0;
            else if (rsv_en && rsv_addr == ADDR_W'(i) && !is_zero_reg(rsv_addr))
                pend_d[i] = 1'b1;
            else if ((wb_en && wb_addr == ADDR_W'(i)) || (wa_en && wa_addr == ADDR_W'(i)))
                pend_d[i] = 1'b0;
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // A same-cycle writeback to the register already satisfies the consumer.
    always_comb begin
        rd_pending = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_pending[p] = pend_q[rd_addr[p]]
                            && !(wa_en && wa_addr == rd_addr[p])
                            && !(wb_en && wb_addr == rd_addr[p])
                            && !is_zero_reg(rd_addr[p]);
        end
    end

    assign pending_cnt = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports with write-through bypass, combinational reads,
// and a load-pending scoreboard for decode hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int ADDR_W   = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NRD-1:0][ADDR_W-1:0] rd_addr,
    output logic [NRD-1:0][DATA_W-1:0] rd_data,
    output logic [NRD-1:0]             rd_pending,
    input  logic                       wa_en,
    input  logic [ADDR_W-1:0]          wa_addr,
    input  logic [DATA_W-1:0]          wa_data,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic                       flush,
    output logic [ADDR_W:0]            pending_cnt
);

    logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Port B is applied first so a same-address port A write overrides it.
    always_comb begin
        mem_d = mem_q;
        if (wb_en && !is_zero_reg(wb_addr)) mem_d[wb_addr] = wb_data;
        if (wa_en && !is_zero_reg(wa_addr)) mem_d[wa_addr] = wa_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem_q[i] <= DATA_W'(init_value(i));
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NRD; p++) begin
            if (is_zero_reg(rd_addr[p]))
                rd_data[p] = '0;
            else if (wa_en && wa_addr == rd_addr[p])
                rd_data[p] = wa_data;
            else if (wb_en && wb_addr == rd_addr[p])
                rd_data[p] = wb_data;
            else
                rd_data[p] = mem_q[rd_addr[p]];
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .ADDR_W   (ADDR_W),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_pending  (rd_pending),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed check of regfile_mp against an array-based reference model.
module tb_regfile_mp;

    logic             clk;
    logic             rst_n;
    logic [1:0][3:0]  rd_addr;
    logic [1:0][23:0] rd_data;
    logic [1:0]       rd_pending;
    logic             wa_en, wb_en, rsv_en, flush;
    logic [3:0]       wa_addr, wb_addr, rsv_addr;
    logic [23:0]      wa_data, wb_data;
    logic [4:0]       pending_cnt;

    int n_cmp = 0;
    int n_err = 0;

    int unsigned m_mem  [16];
    bit          m_pend [16];
    int unsigned init_tbl [6] = '{32'h000000, 32'h001000, 32'h01CAC5,
                                  32'h03FFFF, 32'h03858C, 32'h03EFFF};

    regfile_mp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_pending  (rd_pending),
        .wa_en       (wa_en),
        .wa_addr     (wa_addr),
        .wa_data     (wa_data),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rsv_en      (rsv_en),
        .rsv_addr    (rsv_addr),
        .flush       (flush),
        .pending_cnt (pending_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%06h expected 0x%06h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_mem[i]  = (i < 6) ? init_tbl[i] : 0;
            m_pend[i] = 1'b0;
        end
    endfunction

    function automatic int unsigned exp_read(input int a);
        if (a == 0) return 0;
        if (wa_en && int'(wa_addr) == a) return 32'(wa_data);
        if (wb_en && int'(wb_addr) == a) return 32'(wb_data);
        return m_mem[a];
    endfunction

    function automatic int unsigned exp_pend(input int a);
        if (a == 0) return 0;
        if ((wa_en && int'(wa_addr) == a) || (wb_en && int'(wb_addr) == a)) return 0;
        return m_pend[a] ? 1 : 0;
    endfunction

    function automatic int unsigned exp_cnt();
        int unsigned c = 0;
        for (int i = 0; i < 16; i++) c += m_pend[i] ? 1 : 0;
        return c;
    endfunction

    function automatic void model_clock();
        for (int i = 1; i < 16; i++) begin
            if (flush)                              m_pend[i] = 1'b0;
            else if (rsv_en && int'(rsv_addr) == i) m_pend[i] = 1'b1;
            else if ((wb_en && int'(wb_addr) == i) || (wa_en && int'(wa_addr) == i))
                                                    m_pend[i] = 1'b0;
        end
        if (wb_en && wb_addr != 0) m_mem[wb_addr] = 32'(wb_data);
        if (wa_en && wa_addr != 0) m_mem[wa_addr] = 32'(wa_data);
    endfunction

    task automatic idle_inputs();
        wa_en = 0; wb_en = 0; rsv_en = 0; flush = 0;
        wa_addr = 0; wb_addr = 0; rsv_addr = 0; wa_data = 0; wb_data = 0;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        #2;
        for (int p = 0; p < 2; p++) begin
            check("rd_data", 32'(rd_data[p]), exp_read(int'(rd_addr[p])));
            check("rd_pending", 32'(rd_pending[p]), exp_pend(int'(rd_addr[p])));
        end
        check("pending_cnt", 32'(pending_cnt), exp_cnt());
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    initial begin
        int reset_addrs [6] = '{1, 2, 3, 4, 5, 9};
        int unsigned reset_exp [6] = '{32'h001000, 32'h01CAC5, 32'h03FFFF,
                                       32'h03858C, 32'h03EFFF, 32'h0};
        rst_n = 1'b0;
        rd_addr = '0;
        idle_inputs();
        model_reset();
        #12 rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            rd_addr[0] = 4'(reset_addrs[k]);
            #1 check("reset_val", 32'(rd_data[0]), reset_exp[k]);
        end
        check("reset_cnt", 32'(pending_cnt), 0);

        rd_addr[0] = 4'd7; rd_addr[1] = 4'd0;
        wa_en = 1; wa_addr = 4'd7; wa_data = 24'h123456;
        #1 check("bypass_r7", 32'(rd_data[0]), 32'h123456);
        cycle();
        idle_inputs();
        #1 check("stored_r7", 32'(rd_data[0]), 32'h123456);
        cycle();
        wa_en = 1; wa_addr = 4'd0; wa_data = 24'hFFFFFF;
        #1 check("r0_write_bypass", 32'(rd_data[1]), 0);
        cycle();
        idle_inputs();
        #1 check("r0_stored", 32'(rd_data[1]), 0);

        rd_addr[0] = 4'd3;
        wa_en = 1; wa_addr = 4'd3; wa_data = 24'h000AAA;
        wb_en = 1; wb_addr = 4'd3; wb_data = 24'h000BBB;
        #1 check("dual_bypass_r3", 32'(rd_data[0]), 32'h000AAA);
        cycle();
        idle_inputs();
        #1 check("dual_stored_r3", 32'(rd_data[0]), 32'h000AAA);
        cycle();

        rd_addr[0] = 4'd4;
        rsv_en = 1; rsv_addr = 4'd4;
        #1 check("rsv_not_yet", 32'(rd_pending[0]), 0);
        cycle();
        idle_inputs();
        #1 check("rsv_pending", 32'(rd_pending[0]), 1);
        check("rsv_cnt1", 32'(pending_cnt), 1);
        wb_en = 1; wb_addr = 4'd4; wb_data = 24'h000055;
        #1 check("clear_bypass_pend", 32'(rd_pending[0]), 0);
        cycle();
        idle_inputs();
        #1 check("clear_cnt0", 32'(pending_cnt), 0);
        check("clear_data_r4", 32'(rd_data[0]), 32'h000055);

        rsv_en = 1; rsv_addr = 4'd2; cycle();
        rsv_addr = 4'd6; cycle();
        rsv_addr = 4'd8; cycle();
        idle_inputs();
        #1 check("rsv3_cnt", 32'(pending_cnt), 3);
        flush = 1; rsv_en = 1; rsv_addr = 4'd9;
        cycle();
        idle_inputs();
        rd_addr[0] = 4'd9; rd_addr[1] = 4'd2;
        #1 check("flush_cnt", 32'(pending_cnt), 0);
        check("flush_r9", 32'(rd_pending[0]), 0);
        check("flush_r2", 32'(rd_pending[1]), 0);

        rsv_en = 1; rsv_addr = 4'd4; cycle();
        idle_inputs();
        wa_en = 1; wa_addr = 4'd4; wa_data = 24'h0ABCDE; cycle();
        idle_inputs();
        rsv_en = 1; rsv_addr = 4'd4; cycle();
        idle_inputs();
        rd_addr[0] = 4'd4;
        #1 check("pre_rst_pend", 32'(rd_pending[0]), 1);
        check("pre_rst_data", 32'(rd_data[0]), 32'h0ABCDE);
        rst_n = 1'b0;
        #1 check("async_rst_data", 32'(rd_data[0]), 32'h03858C);
        check("async_rst_pend", 32'(rd_pending[0]), 0);
        check("async_rst_cnt", 32'(pending_cnt), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 400; n++) begin
            rd_addr[0] = 4'($urandom_range(0, 15));
            rd_addr[1] = 4'($urandom_range(0, 15));
            wa_en    = ($urandom_range(0, 2) == 0);
            wa_addr  = 4'($urandom_range(0, 7));
            wa_data  = 24'($urandom);
            wb_en    = ($urandom_range(0, 2) == 0);
            wb_addr  = 4'($urandom_range(0, 7));
            wb_data  = 24'($urandom);
            rsv_en   = ($urandom_range(0, 1) == 0);
            rsv_addr = 4'($urandom_range(0, 15));
            flush    = ($urandom_range(0, 19) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
